vector_load_unit: RTL and testbench

- Producer side of the vector register file write port.
- On a start command, fetches WIDTH elements of WIDTH bits each from data memory over a strided, in-order request/response interface.
- Packs the elements into one vector and issues a single-cycle write (RD, WD, WEV) into the vector register file.
- Sits between the execute-stage load decode and the vector register file write port.

---
 rtl/vector_load_unit.sv | 152 +++++++++++++++
 tb/tb_vector_load_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_load_unit.sv
// Strided vector load: fetches WIDTH elements over an in-order memory port, packs them
// and issues one vector register file write. Optional lane masking under VLU_MASK_EN.
module vector_load_unit #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            base_addr,
   input  logic [ADDR_W-1:0]            stride,
   input  logic [4:0]                   vd,
`ifdef VLU_MASK_EN
   input  logic [WIDTH-1:0]             lane_mask,
`endif
   output logic                         busy,
   output logic                         done,
   output logic                         mem_req,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic                         mem_gnt,
   input  logic                         mem_rvalid,
   input  logic [WIDTH-1:0]             mem_rdata,
   output logic [4:0]                   RD,
   output logic [WIDTH-1:0][WIDTH-1:0]  WD,
   output logic                         WEV
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned LW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

   state_e                      state_q, state_d;
   logic [ADDR_W-1:0]           base_q, base_d;
   logic [ADDR_W-1:0]           stride_q, stride_d;
   logic [4:0]                  rd_q, rd_d;
   logic [WIDTH-1:0][WIDTH-1:0] buf_q, buf_d;
   logic [CW-1:0]               req_cnt_q, req_cnt_d;
   logic [CW-1:0]               resp_cnt_q, resp_cnt_d;
   logic [WIDTH-1:0]            lane_en;

`ifdef VLU_MASK_EN
   logic [WIDTH-1:0]            mask_q, mask_d;
   assign lane_en = mask_q;
`else
   assign lane_en = '1;
`endif

   // Lowest enabled lane at or above 'from'; WIDTH when none remain.
   function automatic logic [CW-1:0] next_lane(input logic [WIDTH-1:0] en,
                                               input logic [CW-1:0]    from);
      logic [CW-1:0] lane;
      lane = CW'(WIDTH);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (en[i] && (CW'(i) >= from)) lane = CW'(i);
      end
      return lane;
   endfunction

   logic [CW-1:0] req_lane;
   logic [CW-1:0] resp_lane;
   logic [CW-1:0] resp_next;
   logic          fetching;
   logic          resp_take;

   // Counters hold the next candidate lane; disabled lanes are skipped by next_lane.
   always_comb begin
      fetching  = (state_q == StFetch);
      req_lane  = next_lane(lane_en, req_cnt_q);
      resp_lane = next_lane(lane_en, resp_cnt_q);
      mem_req   = fetching && (req_lane < CW'(WIDTH));
      mem_addr  = mem_req ? (base_q + stride_q * ADDR_W'(req_lane)) : '0;
      resp_take = fetching && mem_rvalid && (resp_lane < CW'(WIDTH));
      resp_next = resp_take ? next_lane(lane_en, resp_lane + CW'(1)) : resp_lane;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      stride_d   = stride_q;
      rd_d       = rd_q;
      buf_d      = buf_q;
      req_cnt_d  = req_cnt_q;
      resp_cnt_d = resp_cnt_q;
`ifdef VLU_MASK_EN
      mask_d     = mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d     = base_addr;
               stride_d   = stride;
               rd_d       = vd;
               buf_d      = '0;
               req_cnt_d  = '0;
               resp_cnt_d = '0;
`ifdef VLU_MASK_EN
               mask_d     = lane_mask;
`endif
               state_d    = StFetch;
            end
         end
         StFetch: begin
            if (mem_req && mem_gnt) req_cnt_d = req_lane + CW'(1);
            if (resp_take) begin
               buf_d[resp_lane[LW-1:0]] = mem_rdata;
               resp_cnt_d               = resp_lane + CW'(1);
            end
            if (resp_next == CW'(WIDTH)) state_d = StWrite;
         end
         StWrite: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         base_q     <= '0;
         stride_q   <= '0;
         rd_q       <= '0;
         buf_q      <= '0;
         req_cnt_q  <= '0;
         resp_cnt_q <= '0;
`ifdef VLU_MASK_EN
         mask_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         stride_q   <= stride_d;
         rd_q       <= rd_d;
         buf_q      <= buf_d;
         req_cnt_q  <= req_cnt_d;
         resp_cnt_q <= resp_cnt_d;
`ifdef VLU_MASK_EN
         mask_q     <= mask_d;
`endif
      end
   end

   assign busy = (state_q != StIdle);
   assign WEV  = (state_q == StWrite);
   assign done = WEV;
   assign RD   = rd_q;
   assign WD   = buf_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed self-checking bench for vector_load_unit with a negedge-driven memory model
// that grants per a stall setting and answers one cycle after each grant with data = address.
module tb_vector_load_unit;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       base_addr = '0;
   logic [15:0]       stride = '0;
   logic [4:0]        vd = '0;
`ifdef VLU_MASK_EN
   logic [15:0]       lane_mask = 16'hFFFF;
`endif
   logic              busy, done, mem_req, WEV;
   logic [15:0]       mem_addr;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [15:0]       mem_rdata = '0;
   logic [4:0]        RD;
   logic [15:0][15:0] WD;

   vector_load_unit #(.WIDTH(16), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .stride     (stride),
      .vd         (vd),
`ifdef VLU_MASK_EN
      .lane_mask  (lane_mask),
`endif
      .busy       (busy),
      .done       (done),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .RD         (RD),
      .WD         (WD),
      .WEV        (WEV)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int c0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model and write-port monitor state
   int          n_req, req_seen, first_req_cyc, gcnt, stall_lane, stall_left, n_stall;
   int          resp_total, stray_n, wev_cnt, wev_cyc, done_bad;
   logic [15:0] req_log [64];
   logic [15:0] stall_addr [8];
   bit          pend_v = 1'b0;
   logic [15:0] pend_a = '0;
   logic [15:0][15:0] cap_wd;
   logic [4:0]  cap_rd;
   logic        done_at_wev, busy_at_wev;

   always @(negedge clk) begin
      if (pend_v) begin
         mem_rvalid = 1'b1; mem_rdata = pend_a; resp_total++;
      end else if (stray_n > 0) begin
         mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; stray_n--;
      end else begin
         mem_rvalid = 1'b0; mem_rdata = 16'h0000;
      end
      pend_v  = 1'b0;
      mem_gnt = 1'b0;
      if (mem_req === 1'b1) begin
         req_seen++;
         if (gcnt == stall_lane && stall_left > 0) begin
            if (n_stall < 8) stall_addr[n_stall] = mem_addr;
            n_stall++; stall_left--;
         end else begin
            mem_gnt = 1'b1;
            if (n_req == 0) first_req_cyc = cyc;
            if (n_req < 64) req_log[n_req] = mem_addr;
            n_req++; gcnt++;
            pend_v = 1'b1; pend_a = mem_addr;
         end
      end
      if (WEV === 1'b1) begin
         wev_cnt++; wev_cyc = cyc; cap_wd = WD; cap_rd = RD;
         done_at_wev = done; busy_at_wev = busy;
      end
      if (done !== WEV) done_bad++;
   end

   task automatic reset_model();
      n_req = 0; req_seen = 0; first_req_cyc = -1; gcnt = 0; stall_lane = -1; stall_left = 0;
      n_stall = 0; resp_total = 0; stray_n = 0; wev_cnt = 0; wev_cyc = -1; done_bad = 0;
   endtask

   task automatic run_load(input logic [15:0] b, input logic [15:0] s, input logic [4:0] v,
                           output int lat, output bit to);
      @(negedge clk);
      base_addr = b; stride = s; vd = v; start = 1'b1; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (wev_cnt > 0) begin to = 1'b0; break; end
      end
      lat = wev_cyc - c0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      n_checks++; if (mem_addr !== 16'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      n_checks++; if (RD !== 5'd0) begin n_errors++; $display("FAIL reset_rd got %0d want 0", RD); end
      n_checks++; if (WD !== '0) begin n_errors++; $display("FAIL reset_wd got %h want 0", WD); end
      n_checks++; if (WEV !== 1'b0) begin n_errors++; $display("FAIL reset_wev got %b want 0", WEV); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; bit to;
      reset_model();
      run_load(16'h0100, 16'h0001, 5'd5, lat, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL basic_timeout got timeout want WEV"); end
      n_checks++; if (n_req !== 16) begin n_errors++; $display("FAIL basic_nreq got %0d want 16", n_req); end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (req_log[i] !== 16'(32'h0100 + i)) begin
            n_errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, req_log[i], 16'(32'h0100 + i));
         end
      end
      n_checks++; if (first_req_cyc - c0 !== 1) begin n_errors++; $display("FAIL basic_first_req got %0d want 1", first_req_cyc - c0); end
      n_checks++; if (lat !== 18) begin n_errors++; $display("FAIL basic_latency got %0d want 18", lat); end
      n_checks++; if (wev_cnt !== 1) begin n_errors++; $display("FAIL basic_wev_count got %0d want 1", wev_cnt); end
      n_checks++; if (cap_rd !== 5'd5) begin n_errors++; $display("FAIL basic_rd got %0d want 5", cap_rd); end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (cap_wd[i] !== 16'(32'h0100 + i)) begin
            n_errors++; $display("FAIL basic_wd[%0d] got %h want %h", i, cap_wd[i], 16'(32'h0100 + i));
         end
      end
      n_checks++; if (done_at_wev !== 1'b1 || done_bad !== 0) begin n_errors++; $display("FAIL basic_done got done=%b bad=%0d want 1/0", done_at_wev, done_bad); end
      n_checks++; if (busy_at_wev !== 1'b1) begin n_errors++; $display("FAIL basic_busy_write got %b want 1", busy_at_wev); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
      n_checks++; if (WD[15] !== 16'h010F || RD !== 5'd5) begin n_errors++; $display("FAIL basic_hold got wd15=%h rd=%0d want 010f/5", WD[15], RD); end
   endtask

   task automatic test_stall();
      int lat; bit to;
      reset_model();
      stall_lane = 4; stall_left = 3;
      run_load(16'h0100, 16'h0001, 5'd5, lat, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL stall_timeout got timeout want WEV"); end
      n_checks++; if (n_stall !== 3) begin n_errors++; $display("FAIL stall_count got %0d want 3", n_stall); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (stall_addr[i] !== 16'h0104) begin
            n_errors++; $display("FAIL stall_addr[%0d] got %h want 0104", i, stall_addr[i]);
         end
      end
      n_checks++; if (lat !== 21) begin n_errors++; $display("FAIL stall_latency got %0d want 21", lat); end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (cap_wd[i] !== 16'(32'h0100 + i)) begin
            n_errors++; $display("FAIL stall_wd[%0d] got %h want %h", i, cap_wd[i], 16'(32'h0100 + i));
         end
      end
   endtask

   task automatic test_wrap();
      int lat; bit to;
      reset_model();
      run_load(16'hFFF8, 16'h0002, 5'd1, lat, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL wrap_timeout got timeout want WEV"); end
      n_checks++; if (req_log[0] !== 16'hFFF8) begin n_errors++; $display("FAIL wrap_addr0 got %h want fff8", req_log[0]); end
      n_checks++; if (req_log[1] !== 16'hFFFA) begin n_errors++; $display("FAIL wrap_addr1 got %h want fffa", req_log[1]); end
      n_checks++; if (req_log[4] !== 16'h0000) begin n_errors++; $display("FAIL wrap_addr4 got %h want 0000", req_log[4]); end
      n_checks++; if (req_log[15] !== 16'h0016) begin n_errors++; $display("FAIL wrap_addr15 got %h want 0016", req_log[15]); end
      n_checks++; if (cap_wd[4] !== 16'h0000 || cap_wd[15] !== 16'h0016) begin n_errors++; $display("FAIL wrap_wd got %h/%h want 0000/0016", cap_wd[4], cap_wd[15]); end
   endtask

   task automatic test_start_ignored();
      bit seen;
      reset_model();
      @(negedge clk);
      base_addr = 16'h0300; stride = 16'h0001; vd = 5'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      base_addr = 16'h0900; vd = 5'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (WEV === 1'b1) begin seen = 1'b1; break; end
      end
      base_addr = 16'h0A00; vd = 5'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      n_checks++; if (!seen) begin n_errors++; $display("FAIL ign_timeout got timeout want WEV"); end
      n_checks++; if (wev_cnt !== 1) begin n_errors++; $display("FAIL ign_wev_count got %0d want 1", wev_cnt); end
      n_checks++; if (cap_rd !== 5'd7 || RD !== 5'd7) begin n_errors++; $display("FAIL ign_rd got %0d/%0d want 7", cap_rd, RD); end
      n_checks++; if (n_req !== 16) begin n_errors++; $display("FAIL ign_nreq got %0d want 16", n_req); end
      n_checks++; if (req_log[15] !== 16'h030F) begin n_errors++; $display("FAIL ign_addr15 got %h want 030f", req_log[15]); end
      n_checks++; if (cap_wd[9] !== 16'h0309) begin n_errors++; $display("FAIL ign_wd9 got %h want 0309", cap_wd[9]); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ign_busy got %b want 0", busy); end
   endtask

   task automatic test_abort();
      int lat; bit to; bit hit;
      reset_model();
      @(negedge clk);
      base_addr = 16'h0400; stride = 16'h0001; vd = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (resp_total >= 7) begin hit = 1'b1; break; end
      end
      @(negedge clk);
      rst = 1'b0; stray_n = 4;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++; if (!hit) begin n_errors++; $display("FAIL abort_resp got timeout want 7 responses"); end
      n_checks++; if (wev_cnt !== 0) begin n_errors++; $display("FAIL abort_wev got %0d want 0", wev_cnt); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || WEV !== 1'b0) begin n_errors++; $display("FAIL abort_ctrl got busy=%b done=%b wev=%b want 0", busy, done, WEV); end
      n_checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin n_errors++; $display("FAIL abort_mem got req=%b addr=%h want 0", mem_req, mem_addr); end
      n_checks++; if (RD !== 5'd0) begin n_errors++; $display("FAIL abort_rd got %0d want 0", RD); end
      n_checks++; if (WD !== '0) begin n_errors++; $display("FAIL abort_wd got %h want 0", WD); end
      reset_model();
      run_load(16'h0500, 16'h0001, 5'd12, lat, to);
      n_checks++; if (to || wev_cnt !== 1) begin n_errors++; $display("FAIL abort_restart got to=%b wev=%0d want 0/1", to, wev_cnt); end
      n_checks++; if (cap_rd !== 5'd12 || cap_wd[15] !== 16'h050F) begin n_errors++; $display("FAIL abort_restart_data got rd=%0d wd15=%h want 12/050f", cap_rd, cap_wd[15]); end
   endtask

`ifdef VLU_MASK_EN
   task automatic test_mask();
      int lat; bit to;
      logic [15:0] exp_addr [4];
      exp_addr[0] = 16'h0210; exp_addr[1] = 16'h0214; exp_addr[2] = 16'h0218; exp_addr[3] = 16'h021C;
      reset_model();
      lane_mask = 16'h00F0;
      run_load(16'h0200, 16'h0004, 5'd2, lat, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL mask_timeout got timeout want WEV"); end
      n_checks++; if (n_req !== 4) begin n_errors++; $display("FAIL mask_nreq got %0d want 4", n_req); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (req_log[i] !== exp_addr[i]) begin
            n_errors++; $display("FAIL mask_addr[%0d] got %h want %h", i, req_log[i], exp_addr[i]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (cap_wd[i] !== ((i >= 4 && i <= 7) ? exp_addr[i-4] : 16'h0000)) begin
            n_errors++; $display("FAIL mask_wd[%0d] got %h", i, cap_wd[i]);
         end
      end
      reset_model();
      lane_mask = 16'h0000;
      run_load(16'h0200, 16'h0004, 5'd6, lat, to);
      n_checks++; if (to || lat !== 2) begin n_errors++; $display("FAIL mask0_latency got to=%b lat=%0d want 0/2", to, lat); end
      n_checks++; if (req_seen !== 0) begin n_errors++; $display("FAIL mask0_req got %0d want 0", req_seen); end
      n_checks++; if (cap_wd !== '0 || cap_rd !== 5'd6) begin n_errors++; $display("FAIL mask0_wd got %h rd=%0d want 0/6", cap_wd, cap_rd); end
      lane_mask = 16'hFFFF;
   endtask
`endif

   initial begin
      reset_model();
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_start_ignored();
      test_abort();
`ifdef VLU_MASK_EN
      test_mask();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
